// File: rtl/ph_bl_pkg.sv
// Shared types for the pulse-height/baseline FIFO path.
// Used by the frame packer, the FIFO peripheral and their benches.
package ph_bl_pkg;

    localparam logic [15:0] PH_BL_HDR_TAG = 16'hB1F0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP
    } state_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/ph_bl_frame_packer.sv
// Frames NPIX 16-bit pulse-height samples into a header plus NPIX/2 packed
// words; a frame is admitted only if the FIFO can hold all of it.
module ph_bl_frame_packer
    import ph_bl_pkg::*;
#(
    parameter int NPIX   = 64,
    parameter int FREE_W = 10
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic              ph_valid,
    input  logic              ph_sof,
    input  logic [15:0]       ph_data,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              fifo_wr_en,
    output word_t             fifo_wr_data,
    output logic [15:0]       frame_seq,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              err_sof
);

    localparam int CW = $clog2(NPIX);
    localparam logic [FREE_W:0] NEED = (FREE_W + 1)'(NPIX / 2 + 1);
    // cnt holds samples taken after pixel 0, so NPIX-2 marks the last pixel
    localparam logic [CW-1:0] LAST_CNT = CW'(NPIX - 2);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   half, half_n;
    logic          wr_en_n;
    word_t         wr_data_n;
    logic [15:0]   seq_n, fcnt_n, dcnt_n;
    logic          err_n;
    logic          space_ok;

    assign space_ok = {1'b0, fifo_free} >= NEED;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        half_n    = half;
        wr_en_n   = 1'b0;
        wr_data_n = fifo_wr_data;
        seq_n     = frame_seq;
        fcnt_n    = frame_cnt;
        dcnt_n    = drop_cnt;
        err_n     = 1'b0;
        if (ph_valid && ph_sof) begin
            // a sof outside IDLE cuts the running frame short
            err_n = (state != IDLE);
            seq_n = frame_seq + 16'd1;
            cnt_n = '0;
            if (enable && space_ok) begin
                wr_en_n   = 1'b1;
                wr_data_n = {PH_BL_HDR_TAG, seq_n};
                half_n    = ph_data;
                fcnt_n    = frame_cnt + 16'd1;
                state_n   = DATA;
            end else begin
                half_n = '0;
                if (drop_cnt != 16'hFFFF)
                    dcnt_n = drop_cnt + 16'd1;
                state_n = DROP;
            end
        end else if (ph_valid) begin
            unique case (state)
                DATA: begin
                    // even cnt means the sample index is odd
                    if (cnt[0]) begin
                        half_n = ph_data;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = {ph_data, half};
                    end
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state_n = IDLE;
                end
                DROP: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            cnt          <= '0;
            half         <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_seq    <= '0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            err_sof      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            half         <= half_n;
            fifo_wr_en   <= wr_en_n;
            fifo_wr_data <= wr_data_n;
            frame_seq    <= seq_n;
            frame_cnt    <= fcnt_n;
            drop_cnt     <= dcnt_n;
            err_sof      <= err_n;
        end
    end

endmodule
